// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding and sizing helper for the shift-add multiply-accumulate.
package mul_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/shift_add_step.sv
// shift_add_step: one combinational shift-add multiply step (conditional add, shift operands).
module shift_add_step #(
  parameter int N = 5
) (
  input  logic [2*N-1:0] acc,
  input  logic [2*N-1:0] mcand,
  input  logic [N-1:0]   mplier,
  output logic [2*N-1:0] acc_nxt,
  output logic [2*N-1:0] mcand_nxt,
  output logic [N-1:0]   mplier_nxt
);
  assign acc_nxt    = mplier[0] ? acc + mcand : acc;
  assign mcand_nxt  = mcand << 1;
  assign mplier_nxt = mplier >> 1;
endmodule

// File: rtl/unsigned_mul_add.sv
// unsigned_mul_add: sequential product = a*b + c, one multiplier bit per clock.
// Define MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module unsigned_mul_add
  import mul_pkg::*;
#(
  parameter int N = 5
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           valid,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic [N-1:0]   c,
  output logic           busy,
  output logic           ready,
  output logic [2*N-1:0] product
);
  localparam int CW = cnt_w(N);
  state_t state, state_nxt;
  logic [2*N-1:0] acc, mcand, acc_nxt, mcand_nxt;
  logic [N-1:0] mplier, mplier_nxt;
  logic [CW-1:0] count;
  logic done;
  shift_add_step #(.N(N)) u_step (
    .acc       (acc),
    .mcand     (mcand),
    .mplier    (mplier),
    .acc_nxt   (acc_nxt),
    .mcand_nxt (mcand_nxt),
    .mplier_nxt(mplier_nxt)
  );
`ifdef MUL_EARLY_TERM_EN
  assign done = (count == CW'(N - 1)) || (mplier_nxt == '0);
`else
  assign done = count == CW'(N - 1);
`endif
  assign busy = state == RUN;
  always_comb begin
    state_nxt = state == IDLE ? (valid ? RUN : IDLE) : (done ? IDLE : RUN);
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else state <= state_nxt;
  end
  // Result register is written only on the completing step, so it holds until the next one.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      ready   <= 1'b0;
      product <= '0;
    end else begin
      ready <= state == RUN && done;
      if (state == IDLE && valid) begin
        acc    <= {{N{1'b0}}, c};
        mcand  <= {{N{1'b0}}, a};
        mplier <= b;
        count  <= '0;
      end else if (state == RUN) begin
        acc    <= acc_nxt;
        mcand  <= mcand_nxt;
        mplier <= mplier_nxt;
        count  <= count + CW'(1);
        if (done) product <= acc_nxt;
      end
    end
  end
endmodule

// File: tb/tb_unsigned_mul_add.sv
// tb_unsigned_mul_add: directed scoreboard bench for unsigned_mul_add (N=5), either MUL_EARLY_TERM_EN build.
module tb_unsigned_mul_add;
  logic       CLK, RST, valid, busy, ready;
  logic [4:0] a, b, c;
  logic [9:0] product;
  logic [9:0] exp_q[$];
  int         lat_q[$];
  int         compared = 0;
  int         mismatched = 0;

  unsigned_mul_add #(.N(5)) dut (
    .CLK(CLK), .RST(RST), .valid(valid), .a(a), .b(b), .c(c),
    .busy(busy), .ready(ready), .product(product)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lat(input logic [4:0] bb);
    int h;
    h = 0;
`ifdef MUL_EARLY_TERM_EN
    for (int i = 0; i < 5; i++) if (bb[i]) h = i + 1;
    if (h == 0) h = 1;
`else
    h = 5;
`endif
    return h;
  endfunction

  // Drive at a falling edge; returns at the first falling edge after the accept edge.
  task automatic issue(input logic [4:0] ia, input logic [4:0] ib, input logic [4:0] ic);
    valid = 1'b1; a = ia; b = ib; c = ic;
    exp_q.push_back(10'(ia) * 10'(ib) + 10'(ic));
    lat_q.push_back(lat(ib));
    @(negedge CLK);
    valid = 1'b0;
  endtask

  task automatic wait_ready(input int j0, input int b0, input logic chain,
                            input logic [4:0] ia, input logic [4:0] ib, input logic [4:0] ic);
    int j, bc, l;
    logic stable;
    logic [9:0] held, e;
    j = j0; bc = b0; stable = 1'b1; held = product;
    while (!ready && j < 40) begin
      if (busy) bc++;
      if (product !== held) stable = 1'b0;
      @(negedge CLK);
      j++;
    end
    chk("ready_seen", int'(ready), 1);
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    chk("product", int'(product), int'(e));
    chk("latency", j - 1, l);
    chk("busy_cycles", bc, l);
    chk("held_stable", int'(stable), 1);
    chk("ready_busy_low", int'(busy), 0);
    if (chain) issue(ia, ib, ic);
  endtask

  task automatic no_ready(input string tag, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (ready) cnt++;
    end
    chk(tag, cnt, 0);
  endtask

  initial begin
    RST = 1'b0; valid = 1'b0; a = '0; b = '0; c = '0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_product", int'(product), 0);
    RST = 1'b1;
    @(negedge CLK);
    issue(5'd3, 5'd4, 5'd2);
    wait_ready(1, 0, 1'b1, 5'd2, 5'd8, 5'd1);
    wait_ready(1, 0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge CLK);
    issue(5'd31, 5'd31, 5'd31);
    wait_ready(1, 0, 1'b0, 5'd0, 5'd0, 5'd0);
    issue(5'd0, 5'd0, 5'd0);
    wait_ready(1, 0, 1'b0, 5'd0, 5'd0, 5'd0);
    issue(5'd0, 5'd31, 5'd7);
    wait_ready(1, 0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge CLK);
    issue(5'd3, 5'd4, 5'd2);
    valid = 1'b1; a = 5'd1; b = 5'd1; c = 5'd1;
    @(negedge CLK);
    valid = 1'b0;
    @(negedge CLK);
    wait_ready(3, 2, 1'b0, 5'd0, 5'd0, 5'd0);
    no_ready("no_extra_ready", 12);
    chk("ignored_product", int'(product), 14);
    issue(5'd31, 5'd31, 5'd31);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_product", int'(product), 0);
    chk("abort_ready", int'(ready), 0);
    exp_q.delete();
    lat_q.delete();
    @(negedge CLK);
    RST = 1'b1;
    no_ready("no_ready_after_abort", 12);
    issue(5'd5, 5'd1, 5'd3);
    wait_ready(1, 0, 1'b0, 5'd0, 5'd0, 5'd0);
    issue(5'd5, 5'd16, 5'd3);
    wait_ready(1, 0, 1'b0, 5'd0, 5'd0, 5'd0);
    issue(5'd5, 5'd0, 5'd9);
    wait_ready(1, 0, 1'b0, 5'd0, 5'd0, 5'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/unsigned_mul_add.md
Name: unsigned_mul_add

Overview:
- Sequential unsigned shift-add multiply-accumulate: product = a*b + c, one multiplier bit per clock.
- Inverse of the team's restoring divider. Feeding quotient, divisor and remainder back in reconstructs the dividend.
- Used standalone and as the hardware self-check stage behind the divider.
- Handshake style matches the divider: start pulse on valid, one-cycle ready pulse with result.

Parameters:
- N, 5, operand width in bits. Legal range 2..32. Product width is 2N.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-low. Asserted (0) clears all state immediately; deassertion is synchronized externally.
- valid  input  1  start request; sampled only in IDLE.
- a  input  N  multiplicand (e.g. divisor).
- b  input  N  multiplier (e.g. quotient).
- c  input  N  addend (e.g. remainder), zero-extended to 2N.
- busy  output  1  high while an operation is in progress (state RUN).
- ready  output  1  one-cycle pulse: product holds a new valid result.
- product  output  2N  a*b + c; held until the next completion.

Behaviour:
- Reset (RST=0, async): state=IDLE, busy=0, ready=0, product=0, all internal registers 0.
- States are IDLE and RUN.
- IDLE, valid=1 at a rising edge (accept edge k):
  - acc <= {N'b0,c}; mcand <= {N'b0,a}; mplier <= b; count <= 0.
  - state <= RUN; busy=1 from the next cycle.
- IDLE, valid=0: hold; ready=0.
- RUN, each edge:
  - if mplier[0] then acc <= acc + mcand.
  - mcand <= mcand << 1; mplier <= mplier >> 1; count <= count + 1.
- Completion: on the edge performing step N (edge k+N):
  - product <= final acc value (including that step's add); ready <= 1; state <= IDLE.
- Latency: ready is high in the cycle after edge k+N, i.e. N cycles after acceptance, fixed.
- ready is high for exactly one cycle, and only in IDLE.
- valid high during the ready cycle is accepted (back-to-back throughput, one result per N cycles).
- valid while RUN is ignored: no queuing, no corruption of the in-flight operation.
- Operands are only sampled at the accept edge; later changes on a/b/c have no effect.
- Width: acc and mcand are 2N bits. The max result (2^N-1)^2 + (2^N-1) = 2^2N - 2^N cannot overflow; no carry-out port.
- count is $clog2(N+1) bits wide.
- Reset mid-operation aborts immediately. product returns to 0 and no ready pulse is issued.

Optional Feature:
- Macro MUL_EARLY_TERM_EN.
- Defined: completion also occurs on the RUN edge where the shifted mplier becomes 0. product and ready are updated at that edge as above, so latency = max(1, index of highest set bit of b + 1) cycles.
  - b=0 completes after 1 cycle with product = c.
  - busy/ready rules are otherwise unchanged.
- Undefined: fixed N-cycle latency, as specified above.

Decomposition:
- Package mul_pkg:
  - state encoding constants (IDLE=1'b0, RUN=1'b1);
  - helper function for count width;
  - no N-dependent types; N stays a module parameter.
- One natural sub-module, shift_add_step: purely combinational.
  - Inputs: acc, mcand, mplier.
  - Outputs: next acc, mcand, mplier.
  - Instantiated once; keeps the datapath separable from the FSM.

Test Plan:
- N=5, RST low then high; valid=1, a=3, b=4, c=2 -> ready pulse 5 cycles after accept, product=14 (inverts 14/3). busy high exactly 5 cycles.
- Back-to-back: valid held high through the ready cycle with a=2, b=8, c=1 -> second ready 5 cycles later, product=17 (inverts 17/2). First result 14 remains stable until then.
- Corner values: a=31, b=31, c=31 -> product=992. a=0, b=0, c=0 -> product=0. a=0, b=31, c=7 -> product=7.
- Ignore while busy: valid pulsed with a=1, b=1, c=1 two cycles after a 3*4+2 accept -> only one ready, product=14. No extra pulse follows.
- Reset mid-op: RST=0 on cycle 2 of RUN -> busy=0, product=0 immediately. No ready after RST=1 until a new valid.
- With MUL_EARLY_TERM_EN: a=5, b=1, c=3 -> ready 1 cycle after accept, product=8. b=16 -> 5 cycles. b=0, c=9 -> 1 cycle, product=9.
